// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache with 16-byte blocks.
// Hits return the word in the same cycle; misses stall while the block is fetched.
module instruction_cache #(
  parameter int ADDR_BITS  = 10,
  parameter int INDEX_BITS = 3
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          PC,
  output logic [31:0]          INSTRUCTION,
  output logic                 BUSYWAIT,
  output logic                 mem_read,
  output logic [ADDR_BITS-5:0] mem_address,
  input  logic [127:0]         mem_readdata,
  input  logic                 mem_busywait
);

  localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS - 4;
  localparam int BLK_BITS   = ADDR_BITS - 4;
  localparam int NUM_BLOCKS = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t                  state_q, state_d;
  logic [BLK_BITS-1:0]     blk_q, blk_d;
  logic [NUM_BLOCKS-1:0]   valid_q;
  logic [TAG_BITS-1:0]     tag_q  [NUM_BLOCKS];
  logic [127:0]            data_q [NUM_BLOCKS];

  logic [BLK_BITS-1:0]     pc_blk;
  logic [INDEX_BITS-1:0]   pc_idx;
  logic [TAG_BITS-1:0]     pc_tag;
  logic [1:0]              pc_word;
  logic [INDEX_BITS-1:0]   fill_idx;
  logic [TAG_BITS-1:0]     fill_tag;
  logic [127:0]            line;
  logic [31:0]             word;
  logic                    hit;
  logic                    fill_en;
  logic                    unused_pc_bits;

  assign pc_blk   = PC[ADDR_BITS-1:4];
  assign pc_idx   = PC[INDEX_BITS+3:4];
  assign pc_tag   = PC[ADDR_BITS-1:INDEX_BITS+4];
  assign pc_word  = PC[3:2];
  assign fill_idx = blk_q[INDEX_BITS-1:0];
  assign fill_tag = blk_q[BLK_BITS-1:INDEX_BITS];

  // Upper PC bits wrap by truncation; the byte offset within a word is irrelevant.
  assign unused_pc_bits = ^{PC[31:ADDR_BITS], PC[1:0]};

  assign line = data_q[pc_idx];
  assign hit  = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  always_comb begin
    word = line[31:0];
    case (pc_word)
      2'd0: word = line[31:0];
      2'd1: word = line[63:32];
      2'd2: word = line[95:64];
      2'd3: word = line[127:96];
      default: word = line[31:0];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    INSTRUCTION = 32'h0;
    BUSYWAIT    = 1'b0;
    mem_read    = 1'b0;
    mem_address = blk_q;
    fill_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          INSTRUCTION = word;
        end else begin
          BUSYWAIT = 1'b1;
          blk_d    = pc_blk;
          state_d  = MEM_READ;
        end
      end
      MEM_READ: begin
        mem_read = 1'b1;
        BUSYWAIT = 1'b1;
        if (!mem_busywait) begin
          fill_en = 1'b1;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        BUSYWAIT = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are quiet while reset is held, even though the lookup would miss.
    if (!RESET) begin
      INSTRUCTION = 32'h0;
      BUSYWAIT    = 1'b0;
      mem_read    = 1'b0;
      mem_address = '0;
      fill_en     = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      blk_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      if (fill_en) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data storage are never cleared; the valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_readdata;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: a CPU-like fetch driver pushes expected words,
// a monitor pops them whenever the cache presents a valid instruction.
`timescale 1ns/1ps
module tb_instruction_cache;

  logic         CLK;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int n_vec = 0;
  int n_err = 0;
  int lat   = 5;
  int cnt   = 0;
  logic fetch_en = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] pc_q[$];

  instruction_cache #(.ADDR_BITS(10), .INDEX_BITS(3)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory: block 0 holds the known words 0x11..0x44, others a pattern.
  function automatic logic [31:0] blk_word(input logic [5:0] b, input logic [1:0] w);
    logic [31:0] r;
    if (b == 6'd0) begin
      case (w)
        2'd0: r = 32'h11;
        2'd1: r = 32'h22;
        2'd2: r = 32'h33;
        default: r = 32'h44;
      endcase
    end else begin
      r = 32'hA000_0000 | ({26'd0, b} << 8) | {30'd0, w};
    end
    return r;
  endfunction

  assign mem_busywait = mem_read && (cnt < lat);
  assign mem_readdata = mem_busywait ? {4{32'hDEAD_BEEF}} :
                        {blk_word(mem_address, 2'd3), blk_word(mem_address, 2'd2),
                         blk_word(mem_address, 2'd1), blk_word(mem_address, 2'd0)};

  always @(posedge CLK) begin
    if (!mem_read) cnt <= 0;
    else if (cnt < lat) cnt <= cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  // Monitor: every cycle with a valid instruction consumes one expected word.
  logic [31:0] mon_exp, mon_pc;
  always @(negedge CLK) begin
    if (fetch_en && RESET && !BUSYWAIT) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got %h, expected no output", INSTRUCTION);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_pc  = pc_q.pop_front();
        if (INSTRUCTION !== mon_exp) begin
          n_err++;
          $display("FAIL hit_data pc=%h: got %h, expected %h", mon_pc, INSTRUCTION, mon_exp);
        end else begin
          $display("ok   hit_data pc=%h: %h", mon_pc, INSTRUCTION);
        end
      end
    end
  end

  // Present pc until the cache stops stalling; called just after a rising edge.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] exp, input int exp_stall,
                       input logic [31:0] exp_addr);
    int   stall  = 0;
    int   guard  = 0;
    logic saw_rd = 1'b0;
    logic [31:0] addr = 32'h0;
    PC = pc;
    exp_q.push_back(exp);
    pc_q.push_back(pc);
    forever begin
      @(negedge CLK);
      if (!BUSYWAIT) break;
      stall++;
      if (mem_read) begin
        saw_rd = 1'b1;
        addr   = {26'd0, mem_address};
      end
      guard++;
      if (guard > 200) break;
    end
    if (guard > 200) check("fetch_timeout", 32'd1, 32'd0);
    check($sformatf("stall_cycles pc=%h", pc), stall, exp_stall);
    if (exp_stall > 0) check($sformatf("mem_address pc=%h", pc), addr, exp_addr);
    else               check($sformatf("no_mem_read pc=%h", pc), {31'd0, saw_rd}, 32'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int guard;
    RESET = 1'b0;
    PC    = 32'h0;

    // Reset held: outputs quiet even though the lookup would miss.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
    check("reset_mem_read", {31'd0, mem_read}, 32'd0);
    check("reset_instruction", INSTRUCTION, 32'd0);
    check("reset_mem_address", {26'd0, mem_address}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    fetch_en = 1'b1;

    // Cold miss then spatial hits.
    lat = 5;
    fetch(32'h000, 32'h11, 8, 32'h00);
    fetch(32'h004, 32'h22, 0, 32'h0);
    fetch(32'h008, 32'h33, 0, 32'h0);
    fetch(32'h00C, 32'h44, 0, 32'h0);

    // Conflict misses on index 0.
    lat = 2;
    fetch(32'h080, 32'hA000_0800, 5, 32'h08);
    fetch(32'h000, 32'h11,        5, 32'h00);
    fetch(32'h084, 32'hA000_0801, 5, 32'h08);

    // Address truncation.
    lat = 3;
    fetch(32'hFFFF_FFFC, 32'hA000_3F03, 6, 32'h3F);
    fetch(32'h0000_03F8, 32'hA000_3F02, 0, 32'h0);
    fetch(32'h0000_0400, 32'h11,        6, 32'h00);

    // Memory ready on the first MEM_READ cycle.
    lat = 0;
    fetch(32'h0C4, 32'hA000_0C01, 3, 32'h0C);

    // Reset in the second MEM_READ cycle abandons the fill.
    fetch_en = 1'b0;
    lat = 5;
    PC  = 32'h040;
    @(negedge CLK);
    @(posedge CLK);
    @(posedge CLK); #1;
    RESET = 1'b0;
    #1;
    check("midfill_reset_mem_read", {31'd0, mem_read}, 32'd0);
    check("midfill_reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
    fetch_en = 1'b1;
    fetch(32'h040, 32'hA000_0400, 8, 32'h04);

    // PC moves during the fill; the latched block address is kept.
    fetch_en = 1'b0;
    lat = 4;
    PC  = 32'h010;
    @(negedge CLK);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("fill_mem_read", {31'd0, mem_read}, 32'd1);
    check("fill_mem_address", {26'd0, mem_address}, 32'h01);
    @(posedge CLK); #1;
    PC = 32'h020;
    @(negedge CLK);
    check("fill_addr_after_pc_change", {26'd0, mem_address}, 32'h01);
    guard = 0;
    while (mem_read && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    check("update_busywait", {31'd0, BUSYWAIT}, 32'd1);
    fetch_en = 1'b1;
    fetch(32'h020, 32'hA000_0200, 7, 32'h02);
    fetch(32'h014, 32'hA000_0101, 0, 32'h0);
    fetch(32'h018, 32'hA000_0102, 0, 32'h0);
    fetch_en = 1'b0;

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
